// File: rtl/out_stream_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// out_stream_arbiter_pkg
// Shared project package for the output stream arbiter slice: FSM state enum,
// default width/count constants and the index-width helper.
// -----------------------------------------------------------------------------
package out_stream_arbiter_pkg;

  localparam int DEF_NREQ  = 4;   // number of requester streams
  localparam int DEF_OUTW  = 24;  // data width of every stream
  localparam int DEF_BURST = 2;   // maximum beats per grant

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of a requester index: max(1, clog2(n)).
  function automatic int calc_logn(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_stream_arbiter_if.sv
// -----------------------------------------------------------------------------
// out_stream_arbiter_if
// Bundles the requester streams, the output stream and the grant status.
//   slave  : the arbiter side (consumes requests, drives output/status)
//   master : the environment side (drives requests, consumes output/status)
// -----------------------------------------------------------------------------
interface out_stream_arbiter_if
  import out_stream_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int OUTW = DEF_OUTW
);
  localparam int LOGN = calc_logn(NREQ);

  logic [NREQ-1:0][OUTW-1:0] req_tdata;
  logic [NREQ-1:0]           req_tvalid;
  logic [NREQ-1:0]           req_tready;
  logic [OUTW-1:0]           out_tdata;
  logic                      out_tvalid;
  logic                      out_tready;
  logic [LOGN-1:0]           grant_id;
  logic                      busy;

  modport slave (
    input  req_tdata, req_tvalid, out_tready,
    output req_tready, out_tdata, out_tvalid, grant_id, busy
  );

  modport master (
    output req_tdata, req_tvalid, out_tready,
    input  req_tready, out_tdata, out_tvalid, grant_id, busy
  );

endinterface

// File: rtl/out_stream_arbiter_rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin search: returns the first set bit of valid found
// scanning upward from start with wrap-around.
//   valid [NREQ]  candidate vector
//   start [LOGN]  index to begin the scan at (must be < NREQ)
//   idx   [LOGN]  first valid index found (0 when none)
//   found         any valid bit set
// -----------------------------------------------------------------------------
module rr_priority_pick
  import out_stream_arbiter_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int LOGN = calc_logn(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [LOGN-1:0] start,
  output logic [LOGN-1:0] idx,
  output logic            found
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    int cand;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      // Explicit wrap instead of a modulo so non-power-of-two NREQ works.
      cand = int'(start) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = LOGN'(cand);
      end
    end
  end

endmodule

// File: rtl/out_stream_arbiter.sv
// -----------------------------------------------------------------------------
// out_stream_arbiter
// Round-robin arbiter merging NREQ requester streams into one registered
// output stream. A grant costs one IDLE arbitration cycle, then up to BURST
// beats are taken from the granted requester before moving on.
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    out_stream_arbiter_if.slave: requester streams, output stream,
//          grant_id and busy status
// -----------------------------------------------------------------------------
module out_stream_arbiter
  import out_stream_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int OUTW  = DEF_OUTW,
  parameter int BURST = DEF_BURST
) (
  input  logic                clk,
  input  logic                reset,
  out_stream_arbiter_if.slave bus
);

  localparam int LOGN = calc_logn(NREQ);
  localparam int CNTW = (BURST > 1) ? $clog2(BURST) : 1;

  arb_state_e      state_q, state_d;
  logic [LOGN-1:0] rr_ptr_q, rr_ptr_d;
  logic [LOGN-1:0] grant_id_q, grant_id_d;
  logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;
  logic            out_tvalid_q, out_tvalid_d;
  logic [OUTW-1:0] out_tdata_q, out_tdata_d;

  logic [LOGN-1:0] pick_idx;
  logic            pick_found;
  logic            can_load;
  logic            granted_valid;
  logic            accept;
  logic            release_now;

  rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .valid (bus.req_tvalid),
    .start (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // The output register can take a beat when empty or draining this cycle.
  assign can_load      = !out_tvalid_q || bus.out_tready;
  assign granted_valid = bus.req_tvalid[grant_id_q];
  assign accept        = (state_q == LOCKED) && granted_valid && can_load;

  always_comb begin
    bus.req_tready = '0;
    if (state_q == LOCKED && can_load) bus.req_tready[grant_id_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    out_tvalid_d = out_tvalid_q;
    out_tdata_d  = out_tdata_q;
    release_now  = 1'b0;

    if (accept) begin
      out_tdata_d  = bus.req_tdata[grant_id_q];
      out_tvalid_d = 1'b1;
    end else if (bus.out_tready) begin
      out_tvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        // A granted requester going quiet gives up its slot immediately.
        if (!granted_valid) begin
          release_now = 1'b1;
        end else if (accept) begin
          if (beat_cnt_q == CNTW'(BURST - 1)) release_now = 1'b1;
          else                               beat_cnt_d  = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_now) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
      rr_ptr_d   = (grant_id_q == LOGN'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; the data register is reset too, so a held beat is
  // discarded rather than left visible after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      out_tvalid_q <= 1'b0;
      out_tdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
      out_tvalid_q <= out_tvalid_d;
      out_tdata_q  <= out_tdata_d;
    end
  end

  assign bus.out_tdata  = out_tdata_q;
  assign bus.out_tvalid = out_tvalid_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = (state_q == LOCKED);

endmodule

// File: tb/tb_out_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_out_stream_arbiter
// Self-checking bench: a 4-requester DUT compared every cycle against a
// behavioural model (owner/beat counters, modulo round-robin and an output
// scoreboard queue), directed scenarios with literal expectations, random
// traffic, and a 3-requester DUT for the wrap and mid-burst reset cases.
// -----------------------------------------------------------------------------
module tb_out_stream_arbiter;

  localparam int NREQ  = 4;
  localparam int OUTW  = 24;
  localparam int BURST = 2;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic reset3 = 1'b1;

  always #5 clk = ~clk;

  out_stream_arbiter_if #(.NREQ(NREQ), .OUTW(OUTW)) b  ();
  out_stream_arbiter_if #(.NREQ(3),    .OUTW(OUTW)) b3 ();

  out_stream_arbiter #(.NREQ(NREQ), .OUTW(OUTW), .BURST(BURST)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  out_stream_arbiter #(.NREQ(3), .OUTW(OUTW), .BURST(BURST)) u_dut3 (
    .clk   (clk),
    .reset (reset3),
    .bus   (b3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of the 4-requester DUT. m_* describe the DUT state that
  // is visible after the most recent edge; stepped once per cycle.
  // ---------------------------------------------------------------------------
  int              m_owner = -1;  // granted requester, -1 when arbitrating
  int              m_start = 0;   // where the next search begins
  int              m_grant = 0;   // last granted index (shown on grant_id)
  int              m_beats = 0;   // beats taken in the current grant
  logic            m_ov    = 1'b0;
  logic [OUTW-1:0] m_od    = '0;
  logic [OUTW-1:0] sb_q[$];

  always @(negedge clk) begin : compare
    logic            room;
    logic [NREQ-1:0] exp_rdy;

    room    = !m_ov || b.out_tready;
    exp_rdy = (m_owner >= 0 && room) ? NREQ'(1 << m_owner) : '0;

    check("out_tvalid", b.out_tvalid, m_ov);
    check("out_tdata",  b.out_tdata,  m_od);
    check("grant_id",   b.grant_id,   m_grant);
    check("busy",       b.busy,       m_owner >= 0);
    check("req_tready", b.req_tready, exp_rdy);

    if (!reset && b.out_tvalid && b.out_tready) begin
      if (sb_q.size() == 0) check("sb_underflow", sb_q.size(), 1);
      else check("sb_order", b.out_tdata, sb_q.pop_front());
    end

    if (reset) begin
      m_owner = -1; m_start = 0; m_grant = 0; m_beats = 0;
      m_ov = 1'b0; m_od = '0;
      sb_q.delete();
    end else begin
      if (m_ov && b.out_tready) m_ov = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (m_owner < 0 && b.req_tvalid[(m_start + k) % NREQ]) begin
            m_owner = (m_start + k) % NREQ;
            m_grant = m_owner;
            m_beats = 0;
          end
        end
      end else if (!b.req_tvalid[m_owner]) begin
        m_start = (m_owner + 1) % NREQ;
        m_owner = -1;
      end else if (room) begin
        m_od = b.req_tdata[m_owner];
        m_ov = 1'b1;
        sb_q.push_back(m_od);
        m_beats++;
        if (m_beats == BURST) begin
          m_start = (m_owner + 1) % NREQ;
          m_owner = -1;
        end
      end
    end
  end

  task automatic random_inputs();
    for (int i = 0; i < NREQ; i++) begin
      b.req_tdata[i]  = OUTW'($urandom);
      b.req_tvalid[i] = ($urandom_range(0, 99) < 70);
    end
    b.out_tready = ($urandom_range(0, 99) < 60);
  endtask

  initial begin : stimulus
    logic [11:0]     busy_pat;
    int              grants[$];
    logic            prev_busy;
    logic [OUTW-1:0] hold_val;
    bit              seen;

    b.req_tvalid  = '0; b.req_tdata  = '0; b.out_tready  = 1'b1;
    b3.req_tvalid = '0; b3.req_tdata = '0; b3.out_tready = 1'b1;

    // Reset held three cycles under random inputs.
    reset = 1'b1;
    repeat (3) begin random_inputs(); tick(); end
    check("rst_out_tvalid", b.out_tvalid, 0);
    check("rst_out_tdata",  b.out_tdata,  0);
    check("rst_req_tready", b.req_tready, 0);
    check("rst_busy",       b.busy,       0);
    check("rst_grant_id",   b.grant_id,   0);

    reset = 1'b0; b.req_tvalid = '0; b.out_tready = 1'b1;
    tick();

    // Single requester 2: two beats, then rr pointer lands on 3.
    b.req_tvalid = 4'b0100; b.req_tdata[2] = 24'h000011;
    tick();
    check("single_grant", b.grant_id,   2);
    check("single_busy",  b.busy,       1);
    check("single_rdy",   b.req_tready, 4'b0100);
    tick();
    check("single_beat1", b.out_tdata,  24'h000011);
    check("single_v1",    b.out_tvalid, 1);
    b.req_tdata[2] = 24'h000012;
    tick();
    check("single_beat2", b.out_tdata,  24'h000012);
    check("single_idle",  b.busy,       0);
    b.req_tvalid = 4'b1001; b.req_tdata[0] = 24'hA00000; b.req_tdata[3] = 24'hD00000;
    tick();
    check("rr_from_3",    b.grant_id,   3);
    repeat (8) tick();
    b.req_tvalid = '0;
    repeat (3) tick();

    // Saturated requesters from reset: 0,1,2,3,0 with one bubble per grant.
    reset = 1'b1; tick(); reset = 1'b0;
    b.req_tvalid = '1; b.out_tready = 1'b1;
    prev_busy = 1'b0; busy_pat = '0;
    for (int c = 0; c < 13; c++) begin
      for (int i = 0; i < NREQ; i++) b.req_tdata[i] = OUTW'((i << 20) | c);
      tick();
      if (c < 12) busy_pat[11 - c] = b.busy;
      if (b.busy && !prev_busy) grants.push_back(int'(b.grant_id));
      prev_busy = b.busy;
    end
    check("sat_busy_pattern", busy_pat, 12'b110110110110);
    check("sat_grant_count", grants.size(), 5);
    for (int g = 0; g < 5 && g < grants.size(); g++)
      check($sformatf("sat_grant%0d", g), grants[g], g % NREQ);

    // Backpressure: hold out_tready low for five cycles with a beat pending.
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (b.out_tvalid) seen = 1'b1; else tick();
    end
    check("bp_found_beat", seen, 1);
    hold_val = m_od;
    b.out_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NREQ; i++) b.req_tdata[i] = OUTW'($urandom);
      tick();
      check("bp_hold_data",  b.out_tdata,  hold_val);
      check("bp_hold_valid", b.out_tvalid, 1);
      check("bp_no_ready",   b.req_tready, 0);
    end
    b.out_tready = 1'b1;
    repeat (10) tick();
    b.req_tvalid = '0;
    repeat (3) tick();

    // Early release: requester 1 drops after one beat, 2 follows.
    reset = 1'b1; tick(); reset = 1'b0;
    b.req_tvalid = 4'b0110; b.req_tdata[1] = 24'h100001; b.req_tdata[2] = 24'h200001;
    tick();
    check("early_grant1", b.grant_id, 1);
    tick();
    check("early_beat",   b.out_tdata, 24'h100001);
    check("early_locked", b.busy, 1);
    b.req_tvalid = 4'b0100;
    tick();
    check("early_release", b.busy, 0);
    tick();
    check("early_grant2", b.grant_id, 2);
    check("early_busy2",  b.busy, 1);
    b.req_tvalid = '0;
    repeat (3) tick();

    // NREQ=3: pointer wraps 2 -> 0, then reset lands mid-burst.
    reset3 = 1'b1; tick(); reset3 = 1'b0;
    b3.req_tvalid = 3'b100; b3.req_tdata[2] = 24'h000033; b3.req_tdata[0] = 24'h000030;
    tick();
    check("n3_grant2", b3.grant_id, 2);
    tick(); tick();
    check("n3_release", b3.busy, 0);
    b3.req_tvalid = 3'b111;
    tick();
    check("n3_wrap_grant0", b3.grant_id, 0);
    tick();
    check("n3_mid_valid", b3.out_tvalid, 1);
    check("n3_mid_data",  b3.out_tdata,  24'h000030);
    reset3 = 1'b1;
    tick();
    check("n3_rst_valid", b3.out_tvalid, 0);
    check("n3_rst_busy",  b3.busy,       0);
    check("n3_rst_data",  b3.out_tdata,  0);
    check("n3_rst_rdy",   b3.req_tready, 0);
    check("n3_rst_grant", b3.grant_id,   0);
    reset3 = 1'b0; b3.req_tvalid = '0;

    // Random traffic with occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      random_inputs();
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; b.req_tvalid = '0; b.out_tready = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/out_stream_arbiter.md
OUT_STREAM_ARBITER -- requirements
Module: out_stream_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requester streams; values 2..8 supported, including non-powers of two.
REQ-002 Parameter OUTW, default 24: data width of every stream.
REQ-003 Parameter BURST, default 2: maximum beats accepted per grant; must be at least 1.
REQ-004 Derived constant LOGN = max(1, clog2(NREQ)).
REQ-005 clk  in  1  clock; all logic is rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_tdata  in  NREQ x OUTW  requester data, packed array.
REQ-008 req_tvalid  in  NREQ  per-requester valid.
REQ-009 req_tready  out  NREQ  per-requester ready.
REQ-010 out_tdata  out  OUTW  registered output data; feeds the output FIFO write side.
REQ-011 out_tvalid  out  1  registered output valid.
REQ-012 out_tready  in  1  downstream ready.
REQ-013 grant_id  out  LOGN  currently granted requester index.
REQ-014 busy  out  1  high while the FSM is in LOCKED.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and LOCKED.
REQ-016 IDLE, with any req_tvalid high: pick the first valid index scanning upward from rr_ptr with wrap; register it into grant_id; clear beat_cnt; enter LOCKED next cycle.
REQ-017 IDLE with no req_tvalid high: remain in IDLE, with grant_id and rr_ptr unchanged.
REQ-018 IDLE SHALL never accept a beat, so each grant costs exactly one arbitration cycle.
REQ-019 can_load = !out_tvalid || out_tready.
REQ-020 req_tready[i] = (state==LOCKED) && (grant_id==i) && can_load; it is 0 for all other i.
REQ-021 Accept = req_tvalid[grant_id] && req_tready[grant_id].
- On accept: out_tdata <= req_tdata[grant_id]; out_tvalid <= 1.
- Latency: one cycle from accept to out_tvalid.
REQ-022 If out_tready is high and no accept occurs, out_tvalid SHALL go to 0 next cycle.
REQ-023 While out_tvalid is high and out_tready is low, out_tdata and out_tvalid SHALL hold stable.
REQ-024 On accept, beat_cnt SHALL increment.
- If beat_cnt == BURST-1 at the accept: release.
REQ-025 In LOCKED with req_tvalid[grant_id] low: release the same cycle, regardless of can_load.
REQ-026 Release: state <= IDLE; rr_ptr <= grant_id+1, wrapping from NREQ-1 to 0.
REQ-027 beat_cnt SHALL be wide enough to hold BURST-1.
- beat_cnt SHALL never exceed BURST-1.
REQ-028 Data SHALL never be dropped or duplicated, under any pattern of out_tready.
REQ-029 Each accepted requester's beats SHALL appear on out_tdata in acceptance order.
REQ-030 Changes on non-granted req_tvalid or req_tdata SHALL have no effect while LOCKED.

Reset
REQ-031 While reset is high, at the next edge:
- state = IDLE, rr_ptr = 0, beat_cnt = 0, grant_id = 0;
- out_tvalid = 0, out_tdata = 0;
- busy = 0, req_tready = 0.
REQ-032 Reset asserted mid-burst SHALL discard any held output beat and any partial burst; no beat is accepted during reset.

Structure
REQ-033 The FSM state enum (IDLE, LOCKED) SHALL live in the shared project package, alongside the data-width constants.
REQ-034 One sub-module, rr_priority_pick, SHALL be instantiated.
- Combinational: valid vector plus start index in, first-found index plus found flag out.
- Parameterised by NREQ.
REQ-035 All other logic SHALL be in out_stream_arbiter, with registered outputs only.

Verification
REQ-036 Scenarios run with NREQ=4, BURST=2, OUTW=24 unless stated otherwise.
REQ-037 Reset: hold reset 3 cycles with random inputs -> out_tvalid=0, out_tdata=0, req_tready=0, busy=0, grant_id=0.
REQ-038 Single requester:
- Stimulus: req 2 presents 0x000011 then 0x000012; out_tready=1.
- Response: one IDLE cycle, then grant_id=2; out_tdata shows 0x000011 then 0x000012 on consecutive cycles, each one cycle after its accept; then back to IDLE with rr_ptr=3.
REQ-039 Saturated requesters:
- Stimulus: all four req_tvalid continuously high; out_tready=1.
- Response: grant order 0,1,2,3,0; exactly 2 beats per grant; one bubble cycle between grants.
REQ-040 Backpressure:
- Stimulus: out_tvalid=1 with out_tready held low 5 cycles.
- Response: out_tdata constant; all req_tready=0; after release, beats continue in order with no loss.
REQ-041 Early release: granted req 1 drops tvalid after 1 beat -> release the same cycle; the next valid requester (2) is granted after one IDLE cycle.
REQ-042 NREQ=3 wrap: after grant 2 is released, rr_ptr=0; reset asserted mid-burst -> out_tvalid=0 and state IDLE at the next edge.
